// File: rtl/vga_wq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_wq_pkg
//  Description : Shared types and default widths for the VGA framebuffer
//                write queue (state encoding, queue entry layout, helpers).
//  Revision    : 1.0  initial release
// ============================================================================
package vga_wq_pkg;

  localparam int WQ_DEPTH_DEF  = 16;
  localparam int WQ_ADDR_W_DEF = 13;
  localparam int WQ_DATA_W_DEF = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } wq_state_t;

  typedef struct packed {
    logic [WQ_ADDR_W_DEF-1:0] addr;
    logic [WQ_DATA_W_DEF-1:0] data;
  } wq_entry_t;

  // Normal draining is allowed during blanking, or always when not blank-gated.
  function automatic logic can_drain_f(input logic blank, input logic blank_only);
    return blank | ~blank_only;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wq_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : wq_fifo_mem
//  Description : DEPTH x WIDTH queue storage. Synchronous write (shared by
//                normal pushes and coalesce overwrites), combinational read
//                at the read pointer.
//  Revision    : 1.0  initial release
// ============================================================================
module wq_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 38
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/vga_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : vga_write_queue
//  Description : FIFO between execWrite and the framebuffer RAM write port.
//                Drains during blanking (or always when BLANK_ONLY=0), and
//                drains unconditionally on a flush request.
//  Options     : VGA_WQ_COALESCE_EN - a push to the same address as the
//                newest queued entry overwrites that entry's data.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_write_queue
  import vga_wq_pkg::*;
#(
  parameter int DEPTH      = WQ_DEPTH_DEF,
  parameter int ADDR_W     = WQ_ADDR_W_DEF,
  parameter int DATA_W     = WQ_DATA_W_DEF,
  parameter int BLANK_ONLY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vga_we,
  input  logic [ADDR_W-1:0]          vga_addr,
  input  logic [DATA_W-1:0]          vga_data,
  input  logic                       blank,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic                       wq_full,
  output logic                       wq_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       fb_we,
  output logic [ADDR_W-1:0]          fb_addr,
  output logic [DATA_W-1:0]          fb_data
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_ENT_W = ADDR_W + DATA_W;

  wq_state_t           r_state;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_LVL_W-1:0]  r_level;
  logic                r_overflow;
  logic                r_flush_done;
  logic                r_fb_we;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic [DATA_W-1:0]   r_fb_data;

  logic                w_can_drain;
  logic                w_pop;
  logic                w_push;
  logic                w_coalesce;
  logic                w_drop;
  logic [c_LVL_W-1:0]  w_level_next;
  logic                w_mem_we;
  logic [c_PTR_W-1:0]  w_mem_wptr;
  logic [c_ENT_W-1:0]  w_rd_entry;

  assign w_can_drain = can_drain_f(blank, (BLANK_ONLY != 0));

  // FLUSH pops regardless of blank; DRAIN only while draining is permitted.
  assign w_pop = ((r_state == FLUSH) || ((r_state == DRAIN) && w_can_drain))
                 && (r_level != '0);

`ifdef VGA_WQ_COALESCE_EN
  logic [ADDR_W-1:0] r_newest_addr;

  // Address of the most recently appended entry, for coalesce matching.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_newest_addr <= '0;
    end else if (w_push) begin
      r_newest_addr <= vga_addr;
    end
  end

  // The newest entry is only being popped when it is also the oldest one.
  assign w_coalesce = vga_we && (r_level != '0) && (vga_addr == r_newest_addr)
                      && !(w_pop && (r_level == c_LVL_W'(1)));
`else
  assign w_coalesce = 1'b0;
`endif

  // A same-cycle pop frees a slot, so a full queue can still accept.
  assign w_push       = vga_we && !w_coalesce && ((r_level != c_LVL_W'(DEPTH)) || w_pop);
  assign w_drop       = vga_we && !w_coalesce && !w_push;
  assign w_level_next = r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);

  assign w_mem_we   = w_push || w_coalesce;
  assign w_mem_wptr = w_coalesce ? (r_wr_ptr - c_PTR_W'(1)) : r_wr_ptr;

  wq_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (c_ENT_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_mem_we),
    .wr_ptr  (w_mem_wptr),
    .wr_data ({vga_addr, vga_data}),
    .rd_ptr  (r_rd_ptr),
    .rd_data (w_rd_entry)
  );

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_level <= w_level_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Drain control; flush_done pulses when a flush leaves the queue empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (flush_req) begin
            if ((r_level == '0) && !w_push) begin
              r_flush_done <= 1'b1;
            end else begin
              r_state <= FLUSH;
            end
          end else if ((w_level_next != '0) && w_can_drain) begin
            // Entering on next-cycle occupancy keeps push-to-pop at one cycle.
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush_req) begin
            r_state <= FLUSH;
          end else if ((w_level_next == '0) || !w_can_drain) begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          if ((r_level == '0) && !w_push) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Registered framebuffer write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      r_fb_we <= w_pop;
      if (w_pop) begin
        r_fb_addr <= w_rd_entry[c_ENT_W-1:DATA_W];
        r_fb_data <= w_rd_entry[DATA_W-1:0];
      end
    end
  end

  assign flush_done = r_flush_done;
  assign wq_full    = (r_level == c_LVL_W'(DEPTH));
  assign wq_empty   = (r_level == '0);
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign fb_we      = r_fb_we;
  assign fb_addr    = r_fb_addr;
  assign fb_data    = r_fb_data;

endmodule
`default_nettype wire

// File: tb/tb_vga_write_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_write_queue
//  Description : Scoreboard bench for vga_write_queue. A queue-based model
//                predicts occupancy, drops, coalescing and flush completion;
//                a monitor compares every framebuffer write in order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_write_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 25;

  logic              clk = 1'b0;
  logic              rst;
  logic              vga_we;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              blank;
  logic              flush_req;
  logic              flush_done;
  logic              wq_full;
  logic              wq_empty;
  logic [4:0]        level;
  logic              overflow;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  always #5 clk = ~clk;

  vga_write_queue #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BLANK_ONLY (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_we     (vga_we),
    .vga_addr   (vga_addr),
    .vga_data   (vga_data),
    .blank      (blank),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .wq_full    (wq_full),
    .wq_empty   (wq_empty),
    .level      (level),
    .overflow   (overflow),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t mq[$];    // model queue contents, oldest first
  ent_t exq[$];   // entries popped this cycle, due on fb_* next cycle
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   m_over, m_fd, m_in_flush, m_blank_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every framebuffer write must match the next scoreboard entry.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        chk("fb_we", 64'(fb_we), 64'(exq.size() > 0));
        if (fb_we === 1'b1 && exq.size() > 0) begin
          e = exq.pop_front();
          chk("fb_addr", 64'(fb_addr), 64'(e.addr));
          chk("fb_data", 64'(fb_data), 64'(e.data));
        end else if (exq.size() > 0) begin
          void'(exq.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; the model advances from the queue rules, then the
  // status outputs are compared just after the next falling edge.
  task automatic tick(input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic bl, input logic fl);
    bit   pop, coal, acc;
    int   cnt;
    ent_t e;
    vga_we = we; vga_addr = a; vga_data = d; blank = bl; flush_req = fl;
    cnt  = mq.size();
    pop  = (cnt > 0) && (m_in_flush || (bl && m_blank_prev));
    coal = 1'b0;
`ifdef VGA_WQ_COALESCE_EN
    if (we && cnt > 0 && !(pop && cnt == 1)) begin
      coal = (mq[cnt-1].addr == a);
    end
`endif
    acc = we && !coal && (cnt < DEPTH || pop);
    if (we && !coal && !acc) m_over = 1'b1;
    if (pop) exq.push_back(mq.pop_front());
    if (coal) begin
      e = mq.pop_back();
      e.data = d;
      mq.push_back(e);
    end
    if (acc) begin
      e.addr = a;
      e.data = d;
      mq.push_back(e);
    end
    m_fd = 1'b0;
    if (m_in_flush) begin
      if (cnt == 0 && !acc) begin
        m_fd = 1'b1;
        m_in_flush = 1'b0;
      end
    end else if (fl) begin
      if (cnt == 0 && !acc) m_fd = 1'b1;
      else m_in_flush = 1'b1;
    end
    m_blank_prev = bl;
    @(negedge clk);
    #1;
    chk("level",      64'(level),      64'(mq.size()));
    chk("wq_full",    64'(wq_full),    64'(mq.size() == DEPTH));
    chk("wq_empty",   64'(wq_empty),   64'(mq.size() == 0));
    chk("overflow",   64'(overflow),   64'(m_over));
    chk("flush_done", 64'(flush_done), 64'(m_fd));
  endtask

  task automatic idle(input int n, input logic bl);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, bl, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; vga_we = 1'b0; vga_addr = '0; vga_data = '0;
    blank = 1'b0; flush_req = 1'b0;
    mq.delete(); exq.delete();
    m_over = 1'b0; m_fd = 1'b0; m_in_flush = 1'b0; m_blank_prev = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    rst = 1'b0;
    chk("rst_fb_we",      64'(fb_we),      64'd0);
    chk("rst_level",      64'(level),      64'd0);
    chk("rst_empty",      64'(wq_empty),   64'd1);
    chk("rst_full",       64'(wq_full),    64'd0);
    chk("rst_overflow",   64'(overflow),   64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_fb_addr",    64'(fb_addr),    64'd0);
    chk("rst_fb_data",    64'(fb_data),    64'd0);
  endtask

  initial begin
    logic bl;
    logic fl;
    do_reset(2);

    // Three writes held off by active video, released by blanking.
    tick(1'b1, 13'd5, 25'd1, 1'b0, 1'b0);
    tick(1'b1, 13'd6, 25'd2, 1'b0, 1'b0);
    tick(1'b1, 13'd7, 25'd3, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(6, 1'b1);
    idle(2, 1'b0);

    // Seventeen pushes with no drain: last one dropped, overflow sticks.
    for (int i = 0; i < 17; i++) tick(1'b1, 13'(100 + i), 25'(i + 1), 1'b0, 1'b0);
    idle(20, 1'b1);
    idle(2, 1'b0);

    // Reset in the middle of a drain aborts the queue.
    for (int i = 0; i < 8; i++) tick(1'b1, 13'(300 + i), 25'(i + 50), 1'b0, 1'b0);
    idle(2, 1'b1);
    do_reset(2);

    // Full queue under blanking with a push every cycle: no overflow.
    for (int i = 0; i < 16; i++) tick(1'b1, 13'(400 + i), 25'(i + 7), 1'b0, 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < 24; i++) tick(1'b1, 13'(500 + i), 25'(i + 1000), 1'b1, 1'b0);
    idle(20, 1'b1);
    idle(2, 1'b0);

    // Flush during active video.
    for (int i = 0; i < 4; i++) tick(1'b1, 13'(600 + i), 25'(i + 77), 1'b0, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    idle(8, 1'b0);

    // Flush of an empty queue.
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Two writes to the same address.
    tick(1'b1, 13'd9, 25'd1, 1'b0, 1'b0);
    tick(1'b1, 13'd9, 25'd2, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(5, 1'b1);
    idle(2, 1'b0);

    // Randomised traffic with blanking phases and occasional flushes.
    bl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) bl = ~bl;
      fl = ($urandom_range(0, 23) == 0);
      tick(1'($urandom_range(0, 1)), 13'($urandom_range(0, 3)), 25'($urandom), bl, fl);
    end
    idle(2, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b1);
    idle(24, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
